i2c_master_fsm: RTL

I2C_MASTER_FSM -- requirements
Module: i2c_master_fsm

---
 rtl/i2c_pkg.sv | 27 ++
 rtl/i2c_edge_detect.sv | 33 +++
 rtl/i2c_master_fsm.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// ----------------------------------------------------------------
// i2c_pkg: shared state encoding and field widths for the I2C master.
// Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

package i2c_pkg;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    START = 4'd1,
    ADDR  = 4'd2,
    ACK_A = 4'd3,
    WR    = 4'd4,
    ACK_W = 4'd5,
    RD    = 4'd6,
    ACK_R = 4'd7,
    STOP0 = 4'd8,
    STOP1 = 4'd9
  } state_t;

endpackage

`default_nettype wire

// File: rtl/i2c_edge_detect.sv
// ----------------------------------------------------------------
// i2c_edge_detect: single-cycle rise/fall pulses of the data_clk phase clock.
// Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

module i2c_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic data_clk,
  output logic rise,
  output logic fall
);

  logic data_clk_q;
  logic data_clk_d;

  assign data_clk_d = data_clk;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_clk_q <= 1'b0;
    end else begin
      data_clk_q <= data_clk_d;
    end
  end

  assign rise = data_clk & ~data_clk_q;
  assign fall = ~data_clk & data_clk_q;

endmodule

`default_nettype wire

// File: rtl/i2c_master_fsm.sv
// ----------------------------------------------------------------
// i2c_master_fsm: byte-level I2C master sequencer stepped by data_clk edges.
// Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

module i2c_master_fsm
  import i2c_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              data_clk,
  input  logic              ena,
  input  logic [ADDR_W-1:0] addr,
  input  logic              rw,
  input  logic [DATA_W-1:0] data_wr,
  input  logic              sda_in,
  output logic              sda_oe,
  output logic              scl_not_ena,
  output logic              busy,
  output logic [DATA_W-1:0] data_rd,
  output logic              ack_error
);

  logic rise;
  logic fall;

  i2c_edge_detect u_edge (
    .clk      (clk),
    .rst      (rst),
    .data_clk (data_clk),
    .rise     (rise),
    .fall     (fall)
  );

  state_t              state_q, state_d;
  logic [2:0]          bit_cnt_q, bit_cnt_d;
  logic                armed_q, armed_d;
  logic                busy_q, busy_d;
  logic                ack_error_q, ack_error_d;
  logic                sda_oe_q, sda_oe_d;
  logic                scl_not_ena_q, scl_not_ena_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                rw_q, rw_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [DATA_W-1:0]   rx_q, rx_d;
  logic [DATA_W-1:0]   data_rd_q, data_rd_d;

  logic [DATA_W-1:0]   addr_byte;
  logic [2:0]          cnt_dec;
  logic                same_req;
  logic [DATA_W-1:0]   rx_next;

  assign addr_byte = {addr_q, rw_q};
  assign cnt_dec   = bit_cnt_q - 3'd1;
  assign same_req  = (addr == addr_q) && (rw == rw_q);
  assign rx_next   = {rx_q[DATA_W-2:0], sda_in};

  // Falls are tested before rises in every state so a coincident pair resolves to the fall.
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    armed_d       = armed_q;
    busy_d        = busy_q;
    ack_error_d   = ack_error_q;
    sda_oe_d      = sda_oe_q;
    scl_not_ena_d = scl_not_ena_q;
    addr_d        = addr_q;
    rw_d          = rw_q;
    data_d        = data_q;
    rx_d          = rx_q;
    data_rd_d     = data_rd_q;

    case (state_q)
      IDLE: begin
        if (fall && armed_q) begin
          sda_oe_d      = 1'b1;
          scl_not_ena_d = 1'b0;
          armed_d       = 1'b0;
          state_d       = START;
        end else if (ena && !armed_q) begin
          addr_d      = addr;
          rw_d        = rw;
          data_d      = data_wr;
          busy_d      = 1'b1;
          ack_error_d = 1'b0;
          armed_d     = 1'b1;
        end
      end
      START: begin
        if (!fall && rise) begin
          bit_cnt_d = 3'd7;
          sda_oe_d  = ~addr_byte[7];
          state_d   = ADDR;
        end
      end
      ADDR: begin
        if (!fall && rise) begin
          if (bit_cnt_q == 3'd0) begin
            sda_oe_d = 1'b0;
            state_d  = ACK_A;
          end else begin
            bit_cnt_d = cnt_dec;
            sda_oe_d  = ~addr_byte[cnt_dec];
          end
        end
      end
      ACK_A: begin
        if (fall) begin
          if (sda_in) begin
            ack_error_d = 1'b1;
            state_d     = STOP0;
          end
        end else if (rise) begin
          // Still here on a rise means the address was acknowledged.
          bit_cnt_d = 3'd7;
          if (rw_q) begin
            sda_oe_d = 1'b0;
            state_d  = RD;
          end else begin
            sda_oe_d = ~data_q[7];
            state_d  = WR;
          end
        end
      end
      WR: begin
        if (!fall && rise) begin
          if (bit_cnt_q == 3'd0) begin
            sda_oe_d = 1'b0;
            state_d  = ACK_W;
          end else begin
            bit_cnt_d = cnt_dec;
            sda_oe_d  = ~data_q[cnt_dec];
          end
        end
      end
      ACK_W: begin
        if (fall) begin
          if (sda_in) begin
            ack_error_d = 1'b1;
            state_d     = STOP0;
          end else if (ena && same_req) begin
            data_d = data_wr;
          end else begin
            state_d = STOP0;
          end
        end else if (rise) begin
          bit_cnt_d = 3'd7;
          sda_oe_d  = ~data_q[7];
          state_d   = WR;
        end
      end
      RD: begin
        if (fall) begin
          rx_d = rx_next;
          if (bit_cnt_q == 3'd0) begin
            data_rd_d = rx_next;
          end
        end else if (rise) begin
          if (bit_cnt_q == 3'd0) begin
            sda_oe_d = ena && same_req;
            state_d  = ACK_R;
          end else begin
            bit_cnt_d = cnt_dec;
          end
        end
      end
      ACK_R: begin
        if (fall) begin
          // Continue only if the master actually ACKed; a NACKed slave expects a STOP.
          if (!(sda_oe_q && ena && same_req)) begin
            state_d = STOP0;
          end
        end else if (rise) begin
          bit_cnt_d = 3'd7;
          sda_oe_d  = 1'b0;
          state_d   = RD;
        end
      end
      STOP0: begin
        if (!fall && rise) begin
          sda_oe_d = 1'b1;
          state_d  = STOP1;
        end
      end
      STOP1: begin
        if (fall) begin
          sda_oe_d      = 1'b0;
          scl_not_ena_d = 1'b1;
          busy_d        = 1'b0;
          state_d       = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      bit_cnt_q     <= 3'd7;
      armed_q       <= 1'b0;
      busy_q        <= 1'b0;
      ack_error_q   <= 1'b0;
      sda_oe_q      <= 1'b0;
      scl_not_ena_q <= 1'b1;
      addr_q        <= '0;
      rw_q          <= 1'b0;
      data_q        <= '0;
      rx_q          <= '0;
      data_rd_q     <= '0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      armed_q       <= armed_d;
      busy_q        <= busy_d;
      ack_error_q   <= ack_error_d;
      sda_oe_q      <= sda_oe_d;
      scl_not_ena_q <= scl_not_ena_d;
      addr_q        <= addr_d;
      rw_q          <= rw_d;
      data_q        <= data_d;
      rx_q          <= rx_d;
      data_rd_q     <= data_rd_d;
    end
  end

  assign sda_oe      = sda_oe_q;
  assign scl_not_ena = scl_not_ena_q;
  assign busy        = busy_q;
  assign ack_error   = ack_error_q;
  assign data_rd     = data_rd_q;

endmodule

`default_nettype wire
